id_ex_stage: RTL and testbench

Pipeline stage between the register-file read in decode and the ALU in execute. It captures the decode-stage operands, register addresses and control into the EX pipeline register. It forwards results from the MEM and WB stages onto the execute operands. It detects load-use hazards, stalling decode and inserting a bubble, and it honours branch flushes and downstream memory stalls.

---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/fwd_mux.sv | 27 ++
 rtl/id_ex_stage.sv | 136 +++++++++++++
 tb/tb_id_ex_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the decode/execute boundary.
package pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned CTRL_W = 8;

  localparam logic [REG_W-1:0] REG_PC   = 4'hF;
  localparam logic [REG_W-1:0] REG_ZERO = 4'h0;

  // Execute control bundle carried alongside the operands.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              reg_we;
    logic              load;
    logic              mem_we;
  } ex_ctrl_t;

  // Full EX pipeline register contents.
  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [REG_W-1:0] ra1;
    logic [REG_W-1:0] ra2;
    logic             use1;
    logic             use2;
    logic [REG_W-1:0] wa;
    logic [XLEN-1:0]  imm;
    ex_ctrl_t         ctl;
  } ex_reg_t;

  // A bubble clears every field, so an empty slot also presents zero operands.
  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;
  localparam ex_reg_t  EX_BUBBLE      = '0;

  // True when a producer writing 'wa' must be forwarded to a reader of 'ra'.
  // R0 and the PC are never forwarded: their read values are synthesised by decode.
  function automatic logic fwd_hit(input logic             used,
                                   input logic [REG_W-1:0] ra,
                                   input logic             we,
                                   input logic [REG_W-1:0] wa);
    return used && (ra != REG_ZERO) && (ra != REG_PC) && we && (wa == ra);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: MEM result over WB result over the registered read value.
module fwd_mux
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] ra,
  input  logic             used,
  input  logic [XLEN-1:0]  rd,
  input  logic [XLEN-1:0]  res_m,
  input  logic [REG_W-1:0] wa_m,
  input  logic             we_m,
  input  logic [XLEN-1:0]  res_w,
  input  logic [REG_W-1:0] wa_w,
  input  logic             we_w,
  output logic [XLEN-1:0]  op
);

  // MEM is the younger producer, so it wins when both match.
  always_comb begin
    op = rd;
    if (fwd_hit(used, ra, we_m, wa_m)) begin
      op = res_m;
    end else if (fwd_hit(used, ra, we_w, wa_w)) begin
      op = res_w;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall and flush handling.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_d,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [REG_W-1:0]  ra1_d,
  input  logic [REG_W-1:0]  ra2_d,
  input  logic              use1_d,
  input  logic              use2_d,
  input  logic [REG_W-1:0]  wa_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic              reg_we_d,
  input  logic              load_d,
  input  logic              mem_we_d,
  input  logic [XLEN-1:0]   alu_res_m,
  input  logic [REG_W-1:0]  wa_m,
  input  logic              reg_we_m,
  input  logic [XLEN-1:0]   result_w,
  input  logic [REG_W-1:0]  wa_w,
  input  logic              reg_we_w,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              stall_d,
  output logic              valid_e,
  output logic [XLEN-1:0]   srca_e,
  output logic [XLEN-1:0]   srcb_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [REG_W-1:0]  wa_e,
  output logic              reg_we_e,
  output logic              load_e,
  output logic              mem_we_e,
  output logic [CNT_W-1:0]  bubble_cnt
);

  ex_reg_t          ex_q;
  ex_reg_t          dec;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic             lu;
  logic             src_hit;

  // Pack the decode-stage fields into the EX register format.
  always_comb begin
    dec            = EX_BUBBLE;
    dec.valid      = valid_d;
    dec.rd1        = rd1_d;
    dec.rd2        = rd2_d;
    dec.ra1        = ra1_d;
    dec.ra2        = ra2_d;
    dec.use1       = use1_d;
    dec.use2       = use2_d;
    dec.wa         = wa_d;
    dec.imm        = imm_d;
    dec.ctl.ctrl   = ctrl_d;
    dec.ctl.reg_we = reg_we_d;
    dec.ctl.load   = load_d;
    dec.ctl.mem_we = mem_we_d;
  end

  // Gated EX outputs: an empty slot shows no side effects.
  always_comb begin
    valid_e  = ex_q.valid;
    imm_e    = ex_q.valid ? ex_q.imm        : '0;
    ctrl_e   = ex_q.valid ? ex_q.ctl.ctrl   : '0;
    wa_e     = ex_q.valid ? ex_q.wa         : '0;
    reg_we_e = ex_q.valid & ex_q.ctl.reg_we;
    load_e   = ex_q.valid & ex_q.ctl.load;
    mem_we_e = ex_q.valid & ex_q.ctl.mem_we;
  end

  // Load-use detection: a load in EX whose target is read by decode.
  always_comb begin
    src_hit = (use1_d && (ra1_d == wa_e)) || (use2_d && (ra2_d == wa_e));
    lu      = valid_d && valid_e && load_e && reg_we_e &&
              (wa_e != REG_ZERO) && (wa_e != REG_PC) && src_hit;
    stall_d = stall_i | (lu & ~flush_i);
  end

  // EX register update: reset, then downstream stall, flush, load-use bubble, advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= EX_BUBBLE;
      bubble_cnt_q <= '0;
    end else if (stall_i) begin
      ex_q         <= ex_q;
      bubble_cnt_q <= bubble_cnt_q;
    end else if (flush_i) begin
      ex_q         <= EX_BUBBLE;
      bubble_cnt_q <= bubble_cnt_q;
    end else if (lu) begin
      ex_q         <= EX_BUBBLE;
      if (bubble_cnt_q != '1) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end else begin
      ex_q         <= dec;
      bubble_cnt_q <= bubble_cnt_q;
    end
  end

  assign bubble_cnt = bubble_cnt_q;

  fwd_mux u_fwd_a (
    .ra    (ex_q.ra1),
    .used  (ex_q.use1),
    .rd    (ex_q.rd1),
    .res_m (alu_res_m),
    .wa_m  (wa_m),
    .we_m  (reg_we_m),
    .res_w (result_w),
    .wa_w  (wa_w),
    .we_w  (reg_we_w),
    .op    (srca_e)
  );

  fwd_mux u_fwd_b (
    .ra    (ex_q.ra2),
    .used  (ex_q.use2),
    .rd    (ex_q.rd2),
    .res_m (alu_res_m),
    .wa_m  (wa_m),
    .we_m  (reg_we_m),
    .res_w (result_w),
    .wa_w  (wa_w),
    .we_w  (reg_we_w),
    .op    (srcb_e)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

  // Narrow counter so saturation is reachable in a short run.
  localparam int unsigned TB_CNT_W = 8;
  localparam int unsigned SAT_EVENTS = (1 << TB_CNT_W) + 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                valid_d;
  logic [31:0]         rd1_d, rd2_d;
  logic [3:0]          ra1_d, ra2_d;
  logic                use1_d, use2_d;
  logic [3:0]          wa_d;
  logic [31:0]         imm_d;
  logic [7:0]          ctrl_d;
  logic                reg_we_d, load_d, mem_we_d;
  logic [31:0]         alu_res_m;
  logic [3:0]          wa_m;
  logic                reg_we_m;
  logic [31:0]         result_w;
  logic [3:0]          wa_w;
  logic                reg_we_w;
  logic                flush_i, stall_i;
  logic                stall_d, valid_e;
  logic [31:0]         srca_e, srcb_e, imm_e;
  logic [7:0]          ctrl_e;
  logic [3:0]          wa_e;
  logic                reg_we_e, load_e, mem_we_e;
  logic [TB_CNT_W-1:0] bubble_cnt;

  int errors = 0;
  int checks = 0;
  logic [TB_CNT_W-1:0] cnt_before;

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .ra1_d(ra1_d), .ra2_d(ra2_d), .use1_d(use1_d), .use2_d(use2_d), .wa_d(wa_d),
    .imm_d(imm_d), .ctrl_d(ctrl_d), .reg_we_d(reg_we_d), .load_d(load_d),
    .mem_we_d(mem_we_d), .alu_res_m(alu_res_m), .wa_m(wa_m), .reg_we_m(reg_we_m),
    .result_w(result_w), .wa_w(wa_w), .reg_we_w(reg_we_w), .flush_i(flush_i),
    .stall_i(stall_i), .stall_d(stall_d), .valid_e(valid_e), .srca_e(srca_e),
    .srcb_e(srcb_e), .imm_e(imm_e), .ctrl_e(ctrl_e), .wa_e(wa_e),
    .reg_we_e(reg_we_e), .load_e(load_e), .mem_we_e(mem_we_e), .bubble_cnt(bubble_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [3:0] a1, input logic u1, input logic [31:0] d1,
                         input logic [3:0] a2, input logic u2, input logic [31:0] d2,
                         input logic [3:0] w, input logic [31:0] im, input logic [7:0] c,
                         input logic rwe, input logic ld, input logic mwe);
    valid_d = v; ra1_d = a1; use1_d = u1; rd1_d = d1; ra2_d = a2; use2_d = u2; rd2_d = d2;
    wa_d = w; imm_d = im; ctrl_d = c; reg_we_d = rwe; load_d = ld; mem_we_d = mwe;
  endtask

  task automatic set_fwd(input logic mwe, input logic [3:0] mwa, input logic [31:0] mres,
                         input logic wwe, input logic [3:0] wwa, input logic [31:0] wres);
    reg_we_m = mwe; wa_m = mwa; alu_res_m = mres;
    reg_we_w = wwe; wa_w = wwa; result_w = wres;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
    set_dec(1'b1, 4'd1, 1'b1, 32'h1111, 4'd2, 1'b1, 32'h2222, 4'd3, 32'h5, 8'hFF, 1'b1, 1'b1, 1'b1);
    set_fwd(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step(); step();
    checks++; if (valid_e !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_e); end
    checks++; if (srca_e !== 32'h0) begin errors++; $display("FAIL reset_srca got=%h exp=0", srca_e); end
    checks++; if (srcb_e !== 32'h0) begin errors++; $display("FAIL reset_srcb got=%h exp=0", srcb_e); end
    checks++; if ({imm_e, ctrl_e, wa_e, reg_we_e, load_e, mem_we_e} !== 47'h0) begin
      errors++; $display("FAIL reset_gated got imm=%h ctrl=%h wa=%h we=%b ld=%b st=%b exp=0",
                         imm_e, ctrl_e, wa_e, reg_we_e, load_e, mem_we_e); end
    checks++; if (bubble_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", bubble_cnt); end
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL reset_stall_d got=%b exp=0", stall_d); end
    stall_i = 1'b1; #1;
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL reset_stall_d_follow got=%b exp=1", stall_d); end
    stall_i = 1'b0; rst = 1'b0;
  endtask

  task automatic test_capture();
    set_dec(1'b1, 4'd1, 1'b1, 32'h11, 4'd2, 1'b1, 32'h22, 4'd3, 32'h1234, 8'h5A, 1'b1, 1'b0, 1'b0);
    step();
    checks++; if (valid_e !== 1'b1) begin errors++; $display("FAIL cap_valid got=%b exp=1", valid_e); end
    checks++; if (srca_e !== 32'h11) begin errors++; $display("FAIL cap_srca got=%h exp=11", srca_e); end
    checks++; if (srcb_e !== 32'h22) begin errors++; $display("FAIL cap_srcb got=%h exp=22", srcb_e); end
    checks++; if ({imm_e, ctrl_e, wa_e} !== {32'h1234, 8'h5A, 4'd3}) begin
      errors++; $display("FAIL cap_fields got imm=%h ctrl=%h wa=%h exp 1234/5a/3", imm_e, ctrl_e, wa_e); end
    checks++; if ({reg_we_e, load_e, mem_we_e} !== 3'b100) begin
      errors++; $display("FAIL cap_ctl got=%b exp=100", {reg_we_e, load_e, mem_we_e}); end
    // A non-valid decode slot must present gated controls.
    set_dec(1'b0, 4'd1, 1'b1, 32'h11, 4'd2, 1'b1, 32'h22, 4'd3, 32'h1234, 8'h5A, 1'b1, 1'b1, 1'b1);
    step();
    checks++; if ({valid_e, ctrl_e, reg_we_e, load_e, mem_we_e, imm_e} !== 44'h0) begin
      errors++; $display("FAIL cap_gate got v=%b ctrl=%h we=%b ld=%b st=%b imm=%h exp 0",
                         valid_e, ctrl_e, reg_we_e, load_e, mem_we_e, imm_e); end
  endtask

  task automatic test_back_to_back();
    set_dec(1'b1, 4'd6, 1'b1, 32'h6, 4'd7, 1'b1, 32'h7, 4'd1, 32'h0, 8'h01, 1'b1, 1'b0, 1'b0);
    step();
    set_dec(1'b1, 4'd1, 1'b1, 32'hDEAD, 4'd8, 1'b1, 32'h8, 4'd2, 32'h0, 8'h02, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL b2b_no_stall got=%b exp=0", stall_d); end
    step();
    set_fwd(1'b1, 4'd1, 32'h10, 1'b0, 4'd0, 32'h0);
    #1;
    checks++; if (srca_e !== 32'h10) begin errors++; $display("FAIL b2b_fwd_m got=%h exp=10", srca_e); end
    checks++; if (srcb_e !== 32'h8) begin errors++; $display("FAIL b2b_srcb got=%h exp=8", srcb_e); end
    reg_we_m = 1'b0; #1;
    checks++; if (srca_e !== 32'hDEAD) begin errors++; $display("FAIL b2b_no_we got=%h exp=dead", srca_e); end
  endtask

  task automatic test_priority_and_special();
    set_dec(1'b1, 4'd5, 1'b1, 32'h50, 4'd0, 1'b1, 32'h99, 4'd9, 32'h0, 8'h03, 1'b1, 1'b0, 1'b0);
    step();
    set_fwd(1'b1, 4'd5, 32'h1, 1'b1, 4'd5, 32'h2);
    #1;
    checks++; if (srca_e !== 32'h1) begin errors++; $display("FAIL prio_m_over_w got=%h exp=1", srca_e); end
    reg_we_m = 1'b0; #1;
    checks++; if (srca_e !== 32'h2) begin errors++; $display("FAIL prio_w_only got=%h exp=2", srca_e); end
    set_fwd(1'b1, 4'd0, 32'h3, 1'b1, 4'd0, 32'h4);
    #1;
    checks++; if (srcb_e !== 32'h99) begin errors++; $display("FAIL no_fwd_r0 got=%h exp=99", srcb_e); end
    set_dec(1'b1, 4'd15, 1'b1, 32'h108, 4'd15, 1'b0, 32'h77, 4'd9, 32'h0, 8'h03, 1'b1, 1'b0, 1'b0);
    step();
    set_fwd(1'b1, 4'd15, 32'h3, 1'b1, 4'd15, 32'h4);
    #1;
    checks++; if (srca_e !== 32'h108) begin errors++; $display("FAIL no_fwd_pc got=%h exp=108", srca_e); end
    checks++; if (srcb_e !== 32'h77) begin errors++; $display("FAIL no_fwd_unused got=%h exp=77", srcb_e); end
    set_fwd(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
  endtask

  task automatic test_load_use();
    set_dec(1'b1, 4'd10, 1'b1, 32'h1000, 4'd0, 1'b0, 32'h0, 4'd3, 32'h4, 8'h10, 1'b1, 1'b1, 1'b0);
    step();
    cnt_before = bubble_cnt;
    set_dec(1'b1, 4'd3, 1'b1, 32'h77, 4'd2, 1'b1, 32'h22, 4'd4, 32'h0, 8'h04, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", stall_d); end
    step();
    checks++; if (valid_e !== 1'b0) begin errors++; $display("FAIL lu_bubble got=%b exp=0", valid_e); end
    checks++; if (bubble_cnt !== cnt_before + TB_CNT_W'(1)) begin
      errors++; $display("FAIL lu_cnt got=%h exp=%h", bubble_cnt, cnt_before + TB_CNT_W'(1)); end
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL lu_release got=%b exp=0", stall_d); end
    step();
    set_fwd(1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 32'hAB);
    #1;
    checks++; if (srca_e !== 32'hAB) begin errors++; $display("FAIL lu_fwd_w got=%h exp=ab", srca_e); end
    checks++; if ({valid_e, wa_e} !== {1'b1, 4'd4}) begin
      errors++; $display("FAIL lu_advance got v=%b wa=%h exp 1/4", valid_e, wa_e); end
    set_fwd(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
  endtask

  task automatic test_flush();
    set_dec(1'b1, 4'd10, 1'b1, 32'h1000, 4'd0, 1'b0, 32'h0, 4'd3, 32'h4, 8'h10, 1'b1, 1'b1, 1'b0);
    step();
    cnt_before = bubble_cnt;
    set_dec(1'b1, 4'd8, 1'b0, 32'h0, 4'd3, 1'b1, 32'h33, 4'd4, 32'h0, 8'h04, 1'b1, 1'b0, 1'b0);
    flush_i = 1'b1; #1;
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall_d); end
    step();
    flush_i = 1'b0;
    checks++; if ({valid_e, reg_we_e, load_e} !== 3'b000) begin
      errors++; $display("FAIL flush_bubble got=%b exp=000", {valid_e, reg_we_e, load_e}); end
    checks++; if (bubble_cnt !== cnt_before) begin
      errors++; $display("FAIL flush_cnt got=%h exp=%h", bubble_cnt, cnt_before); end
  endtask

  task automatic test_stall();
    set_dec(1'b1, 4'd1, 1'b0, 32'h0, 4'd2, 1'b0, 32'h0, 4'd6, 32'hCAFE, 8'h66, 1'b1, 1'b0, 1'b1);
    step();
    set_dec(1'b1, 4'd1, 1'b0, 32'h0, 4'd2, 1'b0, 32'h0, 4'd7, 32'hBEEF, 8'h77, 1'b1, 1'b0, 1'b0);
    stall_i = 1'b1; flush_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL stall_d_%0d got=%b exp=1", i, stall_d); end
      step();
      checks++; if ({valid_e, imm_e, ctrl_e, wa_e, mem_we_e} !== {1'b1, 32'hCAFE, 8'h66, 4'd6, 1'b1}) begin
        errors++; $display("FAIL stall_hold_%0d got v=%b imm=%h ctrl=%h wa=%h st=%b exp 1/cafe/66/6/1",
                           i, valid_e, imm_e, ctrl_e, wa_e, mem_we_e); end
    end
    stall_i = 1'b0; #1;
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL stall_drop got=%b exp=0", stall_d); end
    step();
    flush_i = 1'b0;
    checks++; if (valid_e !== 1'b0) begin errors++; $display("FAIL stall_then_flush got=%b exp=0", valid_e); end
  endtask

  task automatic test_saturate_and_reset();
    for (int i = 0; i < SAT_EVENTS; i++) begin
      set_dec(1'b1, 4'd10, 1'b1, 32'h1000, 4'd0, 1'b0, 32'h0, 4'd3, 32'h4, 8'h10, 1'b1, 1'b1, 1'b0);
      step();
      set_dec(1'b1, 4'd3, 1'b1, 32'h0, 4'd3, 1'b1, 32'h0, 4'd4, 32'h0, 8'h04, 1'b1, 1'b0, 1'b0);
      step();
    end
    checks++; if (bubble_cnt !== {TB_CNT_W{1'b1}}) begin
      errors++; $display("FAIL sat_cnt got=%h exp=%h", bubble_cnt, {TB_CNT_W{1'b1}}); end
    set_dec(1'b1, 4'd10, 1'b1, 32'h1000, 4'd0, 1'b0, 32'h0, 4'd3, 32'h4, 8'h10, 1'b1, 1'b1, 1'b0);
    step();
    set_dec(1'b1, 4'd3, 1'b1, 32'h5, 4'd3, 1'b1, 32'h6, 4'd4, 32'h0, 8'h04, 1'b1, 1'b0, 1'b0);
    stall_i = 1'b1; flush_i = 1'b1; rst = 1'b1; #1;
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL rst_mid_stall_d got=%b exp=1", stall_d); end
    step();
    checks++; if ({valid_e, srca_e, srcb_e, imm_e, ctrl_e, wa_e, reg_we_e, load_e, mem_we_e, bubble_cnt} !== '0) begin
      errors++; $display("FAIL rst_mid_stall got v=%b a=%h b=%h imm=%h ctrl=%h wa=%h cnt=%h exp 0",
                         valid_e, srca_e, srcb_e, imm_e, ctrl_e, wa_e, bubble_cnt); end
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    set_dec(1'b0, 4'd0, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_back_to_back();
    test_priority_and_special();
    test_load_use();
    test_flush();
    test_stall();
    test_saturate_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
